// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-wait timeout and a retired-instruction counter.
module multicycle_control #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic            branch,
  output logic            ldpc,
  output logic [1:0]      alu_op,
  output logic            mem_err,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_LDI = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3);
  localparam logic [OPW-1:0] OP_STR = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] OP_LDR = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(7);

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [7:0]      wait_q, wait_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic [1:0] tbl_alu_op;
  logic       tbl_alu_src;
  logic       is_str, is_ldr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // ALU control per registered opcode; anything unlisted behaves as NOP
  always_comb begin
    tbl_alu_op  = 2'b00;
    tbl_alu_src = 1'b0;
    case (op_q)
      OP_SUB:          tbl_alu_op = 2'b11;
      OP_LDI, OP_JMP: begin tbl_alu_op = 2'b10; tbl_alu_src = 1'b1; end
      OP_XOR:          tbl_alu_op = 2'b01;
      OP_STR, OP_LDR:  tbl_alu_src = 1'b1;
      OP_BEQ:          tbl_alu_op = 2'b11;
      default: ;
    endcase
  end

  assign is_str = (op_q == OP_STR);
  assign is_ldr = (op_q == OP_LDR);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    ldpc       = 1'b0;
    alu_op     = 2'b00;
    mem_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op  = tbl_alu_op;
        alu_src = tbl_alu_src;
        case (op_q)
          OP_ADD, OP_SUB, OP_LDI, OP_XOR: state_d = S_WB;
          OP_STR, OP_LDR: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          OP_JMP: begin
            ldpc      = 1'b1;
            state_d   = S_FETCH;
            retired_d = retired_q + CNTW'(1);
          end
          OP_BEQ: begin
            branch    = 1'b1;
            ldpc      = zero;
            state_d   = S_FETCH;
            retired_d = retired_q + CNTW'(1);
          end
          default: begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNTW'(1);
          end
        endcase
      end
      S_MEM: begin
        alu_op    = tbl_alu_op;
        alu_src   = tbl_alu_src;
        mem_write = is_str;
        mem_read  = is_ldr;
        // completion wins over timeout when both land in the same cycle
        if (mem_ready) begin
          if (is_ldr) begin
            state_d = S_WB;
          end else begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNTW'(1);
          end
        end else if (wait_q == TMO) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        alu_op     = tbl_alu_op;
        alu_src    = tbl_alu_src;
        reg_write  = 1'b1;
        mem_to_reg = is_ldr;
        state_d    = S_FETCH;
        retired_d  = retired_q + CNTW'(1);
      end
      default: state_d = S_FETCH;
    endcase

    // FETCH decodes from the reset state, so controls are masked while rst is held
    if (rst) begin
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      branch     = 1'b0;
      ldpc       = 1'b0;
      alu_op     = 2'b00;
      mem_err    = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT=3).
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg;
  logic        alu_src, branch, ldpc, mem_err;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;
  logic [11:0] ctrl;

  int checks = 0;
  int failures = 0;

  multicycle_control #(.OPW(4), .MEM_TIMEOUT(3), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .branch(branch), .ldpc(ldpc), .alu_op(alu_op),
    .mem_err(mem_err), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // {ir_load,pc_inc,reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,ldpc,mem_err,alu_op}
  assign ctrl = {ir_load, pc_inc, reg_write, mem_read, mem_write, mem_to_reg,
                 alu_src, branch, ldpc, mem_err, alu_op};

  localparam logic [11:0] C_NONE  = 12'h000;
  localparam logic [11:0] C_FETCH = 12'hC00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state/controls (mem_ready applied first), then step to next cycle.
  task automatic cyc(input string tag, input int st, input logic [11:0] c, input bit rdy = 1'b0);
    mem_ready = rdy;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] opc, input bit zr);
    opcode = opc;
    zero   = zr;
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start(4'd0, 1'b0);                      // ADD
    cyc("add_f", 0, C_FETCH);
    cyc("add_d", 1, C_NONE);
    cyc("add_e", 2, 12'h000);
    cyc("add_w", 4, 12'h200);
    chk("add_ret", 32'(retired), 32'd1);

    start(4'd1, 1'b0);                      // SUB
    cyc("sub_f", 0, C_FETCH);
    cyc("sub_d", 1, C_NONE);
    cyc("sub_e", 2, 12'h003);
    cyc("sub_w", 4, 12'h203);
    chk("sub_ret", 32'(retired), 32'd2);

    start(4'd2, 1'b0);                      // LDI
    cyc("ldi_f", 0, C_FETCH);
    cyc("ldi_d", 1, C_NONE);
    cyc("ldi_e", 2, 12'h022);
    cyc("ldi_w", 4, 12'h222);

    start(4'd3, 1'b0);                      // XOR
    cyc("xor_f", 0, C_FETCH);
    cyc("xor_d", 1, C_NONE);
    cyc("xor_e", 2, 12'h001);
    cyc("xor_w", 4, 12'h201);
    chk("xor_ret", 32'(retired), 32'd4);

    start(4'd5, 1'b0);                      // JMP
    cyc("jmp_f", 0, C_FETCH);
    cyc("jmp_d", 1, C_NONE);
    cyc("jmp_e", 2, 12'h02A);
    chk("jmp_ret", 32'(retired), 32'd5);

    start(4'd7, 1'b1);                      // BEQ taken
    cyc("beq1_f", 0, C_FETCH);
    cyc("beq1_d", 1, C_NONE);
    cyc("beq1_e", 2, 12'h01B);
    start(4'd7, 1'b0);                      // BEQ not taken
    cyc("beq0_f", 0, C_FETCH);
    cyc("beq0_d", 1, C_NONE);
    cyc("beq0_e", 2, 12'h013);
    chk("beq_ret", 32'(retired), 32'd7);

    // opcode is sampled in DECODE only: change it during EXEC to prove op_q is used
    start(4'hF, 1'b1);                      // NOP
    cyc("nop_f", 0, C_FETCH);
    cyc("nop_d", 1, C_NONE);
    opcode = 4'd5;
    cyc("nop_e", 2, C_NONE);
    chk("nop_ret", 32'(retired), 32'd8);

    start(4'd4, 1'b0);                      // STR, ready in 2nd MEM cycle
    cyc("str_f", 0, C_FETCH);
    cyc("str_d", 1, C_NONE);
    cyc("str_e", 2, 12'h020);
    cyc("str_m0", 3, 12'h0A0, 1'b0);
    cyc("str_m1", 3, 12'h0A0, 1'b1);
    chk("str_next", 32'(state), 32'd0);
    chk("str_ret", 32'(retired), 32'd9);

    start(4'd6, 1'b0);                      // LDR, ready on 3rd MEM cycle
    cyc("ldr_f", 0, C_FETCH);
    cyc("ldr_d", 1, C_NONE);
    cyc("ldr_e", 2, 12'h020);
    cyc("ldr_m0", 3, 12'h120, 1'b0);
    cyc("ldr_m1", 3, 12'h120, 1'b0);
    cyc("ldr_m2", 3, 12'h120, 1'b1);
    cyc("ldr_w", 4, 12'h260, 1'b0);
    chk("ldr_ret", 32'(retired), 32'd10);

    start(4'd4, 1'b0);                      // STR timeout: wait 0,1,2,3 then abort
    cyc("tmo_f", 0, C_FETCH);
    cyc("tmo_d", 1, C_NONE);
    cyc("tmo_e", 2, 12'h020);
    cyc("tmo_m0", 3, 12'h0A0);
    cyc("tmo_m1", 3, 12'h0A0);
    cyc("tmo_m2", 3, 12'h0A0);
    cyc("tmo_m3", 3, 12'h0A4);
    cyc("tmo_next", 0, C_FETCH);
    chk("tmo_ret", 32'(retired), 32'd10);

    // ready arriving exactly at the timeout count still completes
    cyc("race_d", 1, C_NONE);               // opcode still STR
    cyc("race_e", 2, 12'h020);
    cyc("race_m0", 3, 12'h0A0);
    cyc("race_m1", 3, 12'h0A0);
    cyc("race_m2", 3, 12'h0A0);
    cyc("race_m3", 3, 12'h0A0, 1'b1);
    chk("race_ret", 32'(retired), 32'd11);

    start(4'd6, 1'b0);                      // LDR with async reset mid-MEM
    cyc("rl_f", 0, C_FETCH);
    cyc("rl_d", 1, C_NONE);
    cyc("rl_e", 2, 12'h020);
    cyc("rl_m0", 3, 12'h120);
    #2;
    rst = 1'b1;
    #1;
    chk("rl_state", 32'(state), 32'd0);
    chk("rl_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("rl_ret", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    chk("rl_hold_ctrl", 32'(ctrl), 32'(C_NONE));
    @(negedge clk);
    rst = 1'b0;
    start(4'd0, 1'b0);
    cyc("post_f", 0, C_FETCH);
    cyc("post_d", 1, C_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
